// File: rtl/clock_report_pkg.sv
// Shared constants and types for the clock report serializer: frame layout,
// CRC parameters, flag bit positions, FSM states and the metric snapshot.
package clock_report_pkg;

  // Frame framing
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 28;

  // CRC-8: init 0, MSB-first, no reflection, no final XOR
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // Byte positions within a frame
  localparam logic [4:0] IDX_SYNC          = 5'd0;
  localparam logic [4:0] IDX_SEQ           = 5'd1;
  localparam logic [4:0] IDX_FLAGS         = 5'd2;
  localparam logic [4:0] IDX_PAYLOAD_FIRST = 5'd3;
  localparam logic [4:0] IDX_PAYLOAD_LAST  = 5'd26;
  localparam logic [4:0] IDX_CRC           = 5'd27;

  // Bit positions inside the flags byte
  localparam int FLAG_SYS_VALID = 0;
  localparam int FLAG_REF_VALID = 1;
  localparam int FLAG_SYNCED    = 2;
  localparam int FLAG_OVERRUN   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Field order matches the wire order of bytes 3..26, so the struct's
  // MSB is the first payload byte on the link.
  typedef struct packed {
    logic [31:0] sys_freq_measured;
    logic [15:0] sys_freq_deviation;
    logic [15:0] sys_stability;
    logic [7:0]  sys_fault_count;
    logic [31:0] ref_freq_measured;
    logic [15:0] ref_freq_deviation;
    logic [15:0] ref_stability;
    logic [7:0]  ref_fault_count;
    logic [31:0] freq_ratio;
    logic [15:0] phase_drift;
  } metrics_t;

  // Assemble the flags byte from the latched status bits.
  function automatic logic [7:0] pack_flags(input logic overrun,
                                            input logic synced,
                                            input logic ref_valid,
                                            input logic sys_valid);
    logic [7:0] f;
    f                 = '0;
    f[FLAG_OVERRUN]   = overrun;
    f[FLAG_SYNCED]    = synced;
    f[FLAG_REF_VALID] = ref_valid;
    f[FLAG_SYS_VALID] = sys_valid;
    return f;
  endfunction

endpackage

// File: rtl/clock_report_serializer_crc8.sv
// Combinational one-byte CRC-8 step (MSB-first, polynomial from the package).
// Also used by the host-side receiver checker.
module crc8_byte_update
  import clock_report_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  // Fold the data byte in, then shift out eight bits with conditional XOR.
  always_comb begin
    crc_next = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[7]) begin
        crc_next = {crc_next[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/clock_report_serializer.sv
// Snapshots clock-monitor metrics on a report request and streams them as a
// 28-byte framed record (sync, seq, flags, payload, CRC-8) over valid/ready.
module clock_report_serializer
  import clock_report_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        enable,
  input  logic        report_req,
  input  logic [31:0] sys_freq_measured,
  input  logic [31:0] ref_freq_measured,
  input  logic [31:0] freq_ratio,
  input  logic [15:0] sys_freq_deviation,
  input  logic [15:0] sys_stability,
  input  logic [15:0] ref_freq_deviation,
  input  logic [15:0] ref_stability,
  input  logic [15:0] phase_drift,
  input  logic [7:0]  sys_fault_count,
  input  logic [7:0]  ref_fault_count,
  input  logic        sys_clock_valid,
  input  logic        ref_clock_valid,
  input  logic        clocks_synchronized,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [7:0]  drop_count
);

  // Frame state
  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  flags_q, flags_d;
  metrics_t    snap_q, snap_d;

  // Request bookkeeping
  logic        overrun_q, overrun_d;
  logic [7:0]  drop_q, drop_d;

  // Registered outputs
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        busy_q, busy_d;

  // Handshake and request decode
  metrics_t    metrics_in;
  logic [7:0]  crc_upd;
  logic        hs;
  logic        final_hs;
  logic        req_en;
  logic        accept;
  logic        overrun_evt;
  logic [4:0]  payload_rel;

  assign metrics_in = '{
    sys_freq_measured:  sys_freq_measured,
    sys_freq_deviation: sys_freq_deviation,
    sys_stability:      sys_stability,
    sys_fault_count:    sys_fault_count,
    ref_freq_measured:  ref_freq_measured,
    ref_freq_deviation: ref_freq_deviation,
    ref_stability:      ref_stability,
    ref_fault_count:    ref_fault_count,
    freq_ratio:         freq_ratio,
    phase_drift:        phase_drift
  };

  // The CRC always folds in the byte currently presented on the link.
  crc8_byte_update u_crc (
    .crc      (crc_q),
    .data     (tx_data_q),
    .crc_next (crc_upd)
  );

  assign hs          = tx_valid_q & tx_ready;
  assign final_hs    = hs & (idx_q == IDX_CRC);
  assign req_en      = report_req & enable;
  // A new frame may start from IDLE or seamlessly on the last byte's handshake.
  assign accept      = req_en & ((state_q == IDLE) | final_hs);
  assign overrun_evt = req_en & (state_q == SEND) & ~final_hs;

  // Next frame state: index advance, CRC update, seq/overrun/drop counters, accept.
  always_comb begin
    // NOTE: every _d signal is defaulted to its _q first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    seq_d     = seq_q;
    flags_d   = flags_q;
    snap_d    = snap_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;

    if (hs && (idx_q >= IDX_SEQ) && (idx_q <= IDX_PAYLOAD_LAST)) begin
      crc_d = crc_upd;
    end

    if (hs) begin
      if (final_hs) begin
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
        idx_d   = IDX_SYNC;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end

    if (overrun_evt) begin
      overrun_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    // Accept overrides the end-of-frame return to IDLE for back-to-back frames.
    if (accept) begin
      snap_d    = metrics_in;
      flags_d   = pack_flags(overrun_q, clocks_synchronized,
                             ref_clock_valid, sys_clock_valid);
      overrun_d = 1'b0;
      idx_d     = IDX_SYNC;
      crc_d     = CRC_INIT;
      state_d   = SEND;
    end
  end

  // Output byte for the next cycle, selected from the next-state frame contents.
  always_comb begin
    tx_valid_d  = (state_d == SEND);
    busy_d      = (state_d == SEND);
    tx_last_d   = (state_d == SEND) && (idx_d == IDX_CRC);
    payload_rel = IDX_PAYLOAD_LAST - idx_d;
    tx_data_d   = '0;
    if (state_d == SEND) begin
      case (idx_d)
        IDX_SYNC:  tx_data_d = SYNC_BYTE;
        IDX_SEQ:   tx_data_d = seq_d;
        IDX_FLAGS: tx_data_d = flags_d;
        IDX_CRC:   tx_data_d = crc_d;
        default:   tx_data_d = 8'(snap_d >> {payload_rel, 3'b000});
      endcase
    end
  end

  // Single state register for the FSM, counters, snapshot and outputs.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= IDX_SYNC;
      crc_q      <= CRC_INIT;
      seq_q      <= '0;
      flags_q    <= '0;
      // NOTE: the snapshot is ordinary flops, not a RAM, so it is reset with everything else.
      snap_q     <= '0;
      overrun_q  <= 1'b0;
      drop_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      seq_q      <= seq_d;
      flags_q    <= flags_d;
      snap_q     <= snap_d;
      overrun_q  <= overrun_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_clock_report_serializer.sv
// Self-checking bench: a frame-level reference model (byte array + position)
// is compared against the serializer every cycle; literal checks pin the model.
`timescale 1ns/1ps
module tb_clock_report_serializer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        report_req = 1'b0;
  logic [31:0] sys_freq_measured = '0, ref_freq_measured = '0, freq_ratio = '0;
  logic [15:0] sys_freq_deviation = '0, sys_stability = '0;
  logic [15:0] ref_freq_deviation = '0, ref_stability = '0, phase_drift = '0;
  logic [7:0]  sys_fault_count = '0, ref_fault_count = '0;
  logic        sys_clock_valid = 1'b0, ref_clock_valid = 1'b0, clocks_synchronized = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic [7:0]  drop_count;

  always #5 clk_sys = ~clk_sys;

  clock_report_serializer dut (
    .clk_sys             (clk_sys),
    .rst                 (rst),
    .enable              (enable),
    .report_req          (report_req),
    .sys_freq_measured   (sys_freq_measured),
    .ref_freq_measured   (ref_freq_measured),
    .freq_ratio          (freq_ratio),
    .sys_freq_deviation  (sys_freq_deviation),
    .sys_stability       (sys_stability),
    .ref_freq_deviation  (ref_freq_deviation),
    .ref_stability       (ref_stability),
    .phase_drift         (phase_drift),
    .sys_fault_count     (sys_fault_count),
    .ref_fault_count     (ref_fault_count),
    .sys_clock_valid     (sys_clock_valid),
    .ref_clock_valid     (ref_clock_valid),
    .clocks_synchronized (clocks_synchronized),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .tx_last             (tx_last),
    .busy                (busy),
    .drop_count          (drop_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Bit-at-a-time CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [7:0] byte_of(input logic [223:0] f, input int i);
    return f[223 - 8*i -: 8];
  endfunction

  // Whole frame from the current metric inputs, packed byte 0 at the MSB end.
  function automatic logic [223:0] build_frame(input logic [7:0] seq, input logic ovr);
    logic [7:0]   b [28];
    logic [191:0] pay;
    logic [223:0] f;
    logic [7:0]   crc;
    pay = {sys_freq_measured, sys_freq_deviation, sys_stability, sys_fault_count,
           ref_freq_measured, ref_freq_deviation, ref_stability, ref_fault_count,
           freq_ratio, phase_drift};
    b[0] = SYNC;
    b[1] = seq;
    b[2] = {4'b0, ovr, clocks_synchronized, ref_clock_valid, sys_clock_valid};
    for (int i = 0; i < 24; i++) b[3 + i] = pay[191 - 8*i -: 8];
    crc = 8'h00;
    for (int i = 1; i <= 26; i++) crc = crc_ref(crc, b[i]);
    b[27] = crc;
    f = '0;
    for (int i = 0; i < 28; i++) f[223 - 8*i -: 8] = b[i];
    return f;
  endfunction

  // Reference model: current frame, position in it, and request bookkeeping.
  logic [223:0] m_frame = '0;
  int           m_pos = 0;
  logic         m_busy = 1'b0;
  logic [7:0]   m_seq = '0, m_drops = '0;
  logic         m_overrun = 1'b0;
  logic         m_hs, m_fin, m_acc, m_ovr;

  assign m_hs  = m_busy & tx_ready;
  assign m_fin = m_hs & (m_pos == 27);
  assign m_acc = report_req & enable & (~m_busy | m_fin);
  assign m_ovr = report_req & enable & m_busy & ~m_fin;

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_pos     <= 0;
      m_seq     <= '0;
      m_drops   <= '0;
      m_overrun <= 1'b0;
    end else begin
      if (m_acc) begin
        m_frame   <= build_frame(m_fin ? m_seq + 8'd1 : m_seq, m_overrun);
        m_pos     <= 0;
        m_busy    <= 1'b1;
        m_overrun <= 1'b0;
      end else begin
        if (m_ovr) m_overrun <= 1'b1;
        if (m_fin) m_busy <= 1'b0;
        else if (m_hs) m_pos <= m_pos + 1;
      end
      if (m_fin) m_seq <= m_seq + 8'd1;
      if (m_ovr && m_drops != 8'hFF) m_drops <= m_drops + 8'd1;
    end
  end

  // Per-cycle comparison and capture of the delivered bytes.
  logic         cmp_en = 1'b0;
  logic [223:0] cap = '0;

  always @(negedge clk_sys) begin
    if (!rst && cmp_en) begin
      check("tx_valid", 224'(tx_valid), 224'(m_busy));
      check("busy", 224'(busy), 224'(m_busy));
      check("drop_count", 224'(drop_count), 224'(m_drops));
      if (m_busy) begin
        check($sformatf("tx_data[%0d]", m_pos), 224'(tx_data), 224'(byte_of(m_frame, m_pos)));
        check($sformatf("tx_last[%0d]", m_pos), 224'(tx_last), 224'(m_pos == 27));
        if (tx_ready) cap[223 - 8*m_pos -: 8] <= tx_data;
      end
    end
  end

  logic rand_ready = 1'b0;
  logic scramble = 1'b0;

  task automatic randomize_metrics();
    sys_freq_measured   = $urandom;
    ref_freq_measured   = $urandom;
    freq_ratio          = $urandom;
    sys_freq_deviation  = 16'($urandom);
    sys_stability       = 16'($urandom);
    ref_freq_deviation  = 16'($urandom);
    ref_stability       = 16'($urandom);
    phase_drift         = 16'($urandom);
    sys_fault_count     = 8'($urandom);
    ref_fault_count     = 8'($urandom);
    sys_clock_valid     = 1'($urandom);
    ref_clock_valid     = 1'($urandom);
    clocks_synchronized = 1'($urandom);
  endtask

  task automatic zero_metrics();
    sys_freq_measured = '0; ref_freq_measured = '0; freq_ratio = '0;
    sys_freq_deviation = '0; sys_stability = '0; ref_freq_deviation = '0;
    ref_stability = '0; phase_drift = '0; sys_fault_count = '0; ref_fault_count = '0;
    sys_clock_valid = 1'b0; ref_clock_valid = 1'b0; clocks_synchronized = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (scramble) randomize_metrics();
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check({"idle ", name}, 224'(busy), 224'(0));
  endtask

  initial begin
    string s;
    logic [7:0] c;
    int n, started, gaps;

    // Reset values
    tick();
    check("reset tx_data", 224'(tx_data), 224'(0));
    check("reset tx_valid", 224'(tx_valid), 224'(0));
    check("reset tx_last", 224'(tx_last), 224'(0));
    check("reset busy", 224'(busy), 224'(0));
    check("reset drop_count", 224'(drop_count), 224'(0));
    tick();
    rst = 1'b0;
    enable = 1'b1;
    cmp_en = 1'b1;

    // Pin the CRC model to the standard CRC-8 check value.
    s = "123456789";
    c = 8'h00;
    for (int i = 0; i < s.len(); i++) c = crc_ref(c, s[i]);
    check("crc model check value", 224'(c), 224'(8'hF4));

    // All-zero frame: busy for exactly 28 cycles
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("zero frame busy cycles", 224'(n), 224'(28));
    check("zero frame bytes", cap, {SYNC, 216'h0});

    // Known metric values
    sys_freq_measured = 32'h05F5E100;
    ref_freq_measured = 32'h00989680;
    sys_clock_valid = 1'b1; ref_clock_valid = 1'b1; clocks_synchronized = 1'b1;
    pulse_req();
    wait_idle("known");
    check("known seq", 224'(byte_of(cap, 1)), 224'(8'h01));
    check("known flags", 224'(byte_of(cap, 2)), 224'(8'h07));
    check("known sys_freq", 224'({byte_of(cap, 3), byte_of(cap, 4), byte_of(cap, 5), byte_of(cap, 6)}),
          224'(32'h05F5E100));
    check("known ref_freq", 224'({byte_of(cap, 12), byte_of(cap, 13), byte_of(cap, 14), byte_of(cap, 15)}),
          224'(32'h00989680));

    // Random backpressure and metrics changing after accept
    rand_ready = 1'b1;
    scramble = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pulse_req();
      wait_idle("random");
    end
    rand_ready = 1'b0;
    scramble = 1'b0;
    tick();

    // Three dropped requests during one frame
    randomize_metrics();
    pulse_req();
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      pulse_req();
    end
    wait_idle("drops");
    check("drop_count after 3", 224'(drop_count), 224'(3));
    pulse_req();
    wait_idle("overrun frame");
    check("overrun flag set", 224'(byte_of(cap, 2) >> 3), 224'(1));
    pulse_req();
    wait_idle("after overrun");
    check("overrun flag cleared", 224'(byte_of(cap, 2) >> 3), 224'(0));

    // Disabled request in IDLE is ignored
    enable = 1'b0;
    pulse_req();
    enable = 1'b1;
    tick();
    check("disabled busy", 224'(busy), 224'(0));
    check("disabled drops", 224'(drop_count), 224'(3));

    // Reset, then 257 back-to-back frames
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("drop_count after reset", 224'(drop_count), 224'(0));
    scramble = 1'b1;
    pulse_req();
    started = 1;
    gaps = 0;
    for (int cyc = 0; cyc < 257 * 28 + 100 && !(started == 257 && !busy); cyc++) begin
      if (!busy) gaps++;
      report_req = tx_valid && tx_last && (started < 257);
      if (report_req) started++;
      tick();
      report_req = 1'b0;
    end
    scramble = 1'b0;
    check("b2b idle gaps", 224'(gaps), 224'(0));
    check("b2b frames", 224'(started), 224'(257));
    check("b2b last seq", 224'(byte_of(cap, 1)), 224'(8'h00));
    check("b2b done", 224'(busy), 224'(0));

    // Reset in the middle of a frame
    randomize_metrics();
    pulse_req();
    repeat (2) tick();
    pulse_req();
    n = 0;
    while (m_pos != 10 && n < 100) begin
      tick();
      n++;
    end
    check("reached byte 10", 224'(byte_of(m_frame, 10)), 224'(tx_data));
    rst = 1'b1;
    #1;
    check("midreset tx_valid", 224'(tx_valid), 224'(0));
    check("midreset busy", 224'(busy), 224'(0));
    check("midreset drop_count", 224'(drop_count), 224'(0));
    tick();
    rst = 1'b0;
    randomize_metrics();
    pulse_req();
    wait_idle("post reset");
    check("post reset seq", 224'(byte_of(cap, 1)), 224'(8'h00));
    check("post reset overrun", 224'(byte_of(cap, 2) >> 3), 224'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
